// File: rtl/clk_div_sched_pkg.sv
// Shared types and constants for the clock-divider scheduler.
// Holds the FSM state encoding, divisor/settle widths and the settle-length helper.
package clk_div_sched_pkg;

    localparam int DIV_W = 16;
    localparam int SET_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWITCH,
        ST_SETTLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    // Two half-periods per divisor step; a zero divisor still needs two cycles to settle.
    function automatic logic [SET_W-1:0] settle_len(input logic [DIV_W-1:0] div);
        if (div == '0) begin
            return SET_W'(2);
        end
        return {div, 1'b0};
    endfunction

endpackage

// File: rtl/clk_div_sched_rr.sv
// Combinational round-robin arbiter: the search starts at ptr and ascends with wrap.
// Produces a one-hot winner, its index and a valid flag.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] winner,
    output logic [ID_W-1:0]  index,
    output logic             valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                index       = idx;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Schedules exclusive use of one clock divider among N_REQ requesters.
// Optional grant hold limit enabled by defining CLK_DIV_SCHED_HOLD_LIMIT_EN.
module clk_div_sched
    import clk_div_sched_pkg::*;
#(
    parameter int               N_REQ    = 4,
    parameter logic [DIV_W-1:0] IDLE_DIV = 16'd0,
    parameter logic [15:0]      HOLD_MAX = 16'hFFFF,
    localparam int              ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [DIV_W*N_REQ-1:0] div_req,
    output logic [DIV_W-1:0]       div_out,
    output logic [N_REQ-1:0]       gnt,
    output logic [ID_W-1:0]        cur_id,
    output logic                   busy,
    output logic                   timeout
);

    state_t             state;
    state_t             next_state;
    logic [DIV_W-1:0]   div_lat;
    logic [DIV_W-1:0]   div_sel;
    logic [ID_W-1:0]    ptr;
    logic [SET_W-1:0]   settle_cnt;
    logic [N_REQ-1:0]   arb_req;
    logic [N_REQ-1:0]   arb_winner;
    logic [ID_W-1:0]    arb_index;
    logic               arb_valid;
    logic [N_REQ-1:0]   cur_oh;
    logic [N_REQ-1:0]   gnt_nxt;
    logic               hold_expired;
    logic               cur_req;

    assign cur_req = req[cur_id];

`ifdef CLK_DIV_SCHED_HOLD_LIMIT_EN
    logic [15:0]      hold_cnt;
    logic [N_REQ-1:0] blocked;
    logic             timeout_nxt;

    assign hold_expired = (hold_cnt >= HOLD_MAX);
    assign timeout_nxt  = (state == ST_GRANT) && cur_req && hold_expired;
    // A revoked requester stays masked until it has dropped its request once.
    assign arb_req      = req & ~blocked;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            blocked  <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= (state == ST_GRANT) ? hold_cnt + 1'b1 : '0;
            blocked  <= (blocked & req) | (timeout_nxt ? cur_oh : '0);
            timeout  <= timeout_nxt;
        end
    end
`else
    assign hold_expired = 1'b0;
    assign arb_req      = req;
    assign timeout      = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (arb_req),
        .ptr    (ptr),
        .winner (arb_winner),
        .index  (arb_index),
        .valid  (arb_valid)
    );

    always_comb begin
        div_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_index == ID_W'(i)) begin
                div_sel = div_req[DIV_W*i +: DIV_W];
            end
        end
    end

    always_comb begin
        cur_oh         = '0;
        cur_oh[cur_id] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (arb_valid) next_state = ST_SWITCH;
            end
            ST_SWITCH: begin
                if (!cur_req)                 next_state = ST_RELEASE;
                else if (div_lat == div_out)  next_state = ST_GRANT;
                else                          next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!cur_req)                         next_state = ST_RELEASE;
                else if (settle_cnt == SET_W'(1))     next_state = ST_GRANT;
            end
            ST_GRANT: begin
                if (!cur_req || hold_expired) next_state = ST_RELEASE;
            end
            ST_RELEASE: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // The grant falls on the same edge that leaves GRANT.
    always_comb begin
        busy    = (state != ST_IDLE);
        gnt_nxt = '0;
        if ((state == ST_GRANT) && cur_req && !hold_expired) begin
            gnt_nxt = cur_oh;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            div_out    <= IDLE_DIV;
            div_lat    <= '0;
            gnt        <= '0;
            cur_id     <= '0;
            ptr        <= '0;
            settle_cnt <= '0;
        end else begin
            gnt <= gnt_nxt;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        cur_id  <= arb_index;
                        div_lat <= div_sel;
                    end
                end
                ST_SWITCH: begin
                    if (div_lat != div_out) begin
                        div_out    <= div_lat;
                        settle_cnt <= settle_len(div_lat);
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
                ST_RELEASE: begin
                    ptr <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched with hand-computed expectations.
// The hold-limit section runs only when CLK_DIV_SCHED_HOLD_LIMIT_EN is defined.
module tb_clk_div_sched;

`ifdef CLK_DIV_SCHED_HOLD_LIMIT_EN
    localparam logic [15:0] TB_HOLD = 16'd10;
`else
    localparam logic [15:0] TB_HOLD = 16'hFFFF;
`endif

    logic        clk_in;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] div_req;
    logic [15:0] div_out;
    logic [3:0]  gnt;
    logic [1:0]  cur_id;
    logic        busy;
    logic        timeout;

    int vectors;
    int miscompares;
    int cnt;
    logic [3:0] seen_gnt;

    clk_div_sched #(
        .N_REQ    (4),
        .IDLE_DIV (16'd0),
        .HOLD_MAX (TB_HOLD)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .req     (req),
        .div_req (div_req),
        .div_out (div_out),
        .gnt     (gnt),
        .cur_id  (cur_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input int limit);
        for (int t = 0; t < limit && gnt == 4'b0; t++) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        req     = 4'b0;
        div_req = 64'd0;
        tick();
        tick();
        check("rst_div_out", 32'(div_out), 32'd0);
        check("rst_gnt",     32'(gnt),     32'd0);
        check("rst_cur_id",  32'(cur_id),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // New divisor 3 from reset: DIV_OUT at cycle 2, GNT at cycle 9
        rst_n = 1'b1;
        req   = 4'b0001;
        div_req[15:0] = 16'd3;
        tick();
        check("sw_busy", 32'(busy), 32'd1);
        tick();
        check("div_out_c2", 32'(div_out), 32'd3);
        for (int i = 0; i < 6; i++) tick();
        check("gnt_c8", 32'(gnt), 32'd0);
        tick();
        check("gnt_c9", 32'(gnt), 32'b0001);
        div_req[15:0] = 16'd7;
        tick();
        tick();
        check("div_ignored", 32'(div_out), 32'd3);
        check("gnt_hold",    32'(gnt),     32'b0001);
        req = 4'b0000;
        tick();
        check("rel_gnt",  32'(gnt),  32'd0);
        check("rel_busy", 32'(busy), 32'd1);
        tick();
        check("idle_busy", 32'(busy),    32'd0);
        check("idle_div",  32'(div_out), 32'd3);

        // Same divisor again: no settle, grant three cycles after request
        div_req[15:0] = 16'd3;
        req = 4'b0001;
        tick();
        tick();
        check("eq_gnt_c2", 32'(gnt), 32'd0);
        tick();
        check("eq_gnt_c3", 32'(gnt), 32'b0001);
        req = 4'b0000;
        tick();
        tick();

        // Reset to put the round-robin pointer back at zero
        rst_n   = 1'b0;
        div_req = 64'd0;
        tick();
        rst_n = 1'b1;
        check("rst2_div", 32'(div_out), 32'd0);

        // All four requesting: grant order 0,1,2,3,0
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(20);
            check($sformatf("rr_gnt_%0d", n), 32'(gnt),    32'(1 << (n % 4)));
            check($sformatf("rr_id_%0d", n),  32'(cur_id), 32'(n % 4));
            for (int i = 0; i < 4; i++) tick();
            req[n % 4] = 1'b0;
            tick();
            req[n % 4] = 1'b1;
        end
        req = 4'b0000;
        tick();
        tick();

        // Requester 2 aborts mid-settle with divisor 100
        req = 4'b0100;
        div_req[47:32] = 16'd100;
        tick();
        check("ab_cur_id", 32'(cur_id), 32'd2);
        tick();
        check("ab_div", 32'(div_out), 32'd100);
        seen_gnt = 4'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_gnt = seen_gnt | gnt;
        end
        check("ab_busy_settle", 32'(busy), 32'd1);
        req = 4'b0000;
        tick();
        seen_gnt = seen_gnt | gnt;
        check("ab_rel_busy", 32'(busy), 32'd1);
        tick();
        seen_gnt = seen_gnt | gnt;
        check("ab_no_gnt",   32'(seen_gnt), 32'd0);
        check("ab_idle",     32'(busy),     32'd0);
        check("ab_div_keep", 32'(div_out),  32'd100);

        // Reset during GRANT (requester 1, divisor already 100)
        req = 4'b0010;
        div_req[31:16] = 16'd100;
        tick();
        tick();
        tick();
        check("g_gnt", 32'(gnt), 32'b0010);
        rst_n = 1'b0;
        tick();
        check("gr_div",    32'(div_out), 32'd0);
        check("gr_gnt",    32'(gnt),     32'd0);
        check("gr_cur_id", 32'(cur_id),  32'd0);
        check("gr_busy",   32'(busy),    32'd0);
        check("gr_tmo",    32'(timeout), 32'd0);
        rst_n   = 1'b1;
        div_req = 64'd0;
        req     = 4'b1010;
        tick();
        check("ptr_rst_id", 32'(cur_id), 32'd1);
        tick();
        tick();
        check("ptr_rst_gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick();
        tick();

`ifdef CLK_DIV_SCHED_HOLD_LIMIT_EN
        // Hold limit 10: forced release, one timeout pulse, no regrant while held
        req = 4'b0010;
        wait_gnt(20);
        cnt = 0;
        while (gnt != 4'b0 && cnt < 30) begin
            cnt++;
            tick();
        end
        check("hl_cycles", 32'(cnt),     32'd10);
        check("hl_tmo_on", 32'(timeout), 32'd1);
        tick();
        check("hl_tmo_off", 32'(timeout), 32'd0);
        seen_gnt = 4'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_gnt = seen_gnt | gnt;
        end
        check("hl_no_regrant", 32'(seen_gnt), 32'd0);
        req = 4'b0000;
        tick();
        req = 4'b0010;
        wait_gnt(20);
        check("hl_regrant", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
